serial_add_sequencer: RTL

//  Multi-cycle bit-serial add/subtract unit built around one 1-bit full-adder cell (FullAdderNew).

---
 rtl/serial_add_sequencer_pkg.sv | 21 ++
 rtl/serial_add_sequencer_fa.sv | 14 +
 rtl/serial_add_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer:
// FSM state codes, op-select encoding and the flag bundle.
package serial_add_sequencer_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Op-select encoding shared with the single-cycle ALU control.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
  } flags_t;

  localparam flags_t FLAGS_RESET = '{cout: 1'b0, overflow: 1'b0, zero: 1'b1};

endpackage

// File: rtl/serial_add_sequencer_fa.sv
// One-bit full-adder cell (FullAdderNew), the only arithmetic element
// of the serial sequencer.
module serial_add_sequencer_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract unit: one full adder sequenced LSB first over
// WIDTH cycles behind a start/ready/busy/done handshake.
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [WIDTH-1:0] sr_reg;
  logic [WIDTH-1:0] result_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  flags_t           flags_reg;

  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] sr_next;

  serial_add_sequencer_fa u_fa (
    .a    (sa_reg[0]),
    .b    (sb_reg[0]),
    .cin  (carry_reg),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));
  assign sr_next  = {fa_sum, sr_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      sa_reg     <= '0;
      sb_reg     <= '0;
      sr_reg     <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      flags_reg  <= FLAGS_RESET;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            sa_reg    <= a;
            sb_reg    <= (sub == OP_SUB) ? ~b : b;
            carry_reg <= (sub == OP_SUB);
            cnt_reg   <= '0;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          sa_reg    <= sa_reg >> 1;
          sb_reg    <= sb_reg >> 1;
          sr_reg    <= sr_next;
          carry_reg <= fa_cout;
          cnt_reg   <= cnt_reg + 1'b1;
          if (last_bit) begin
            // On the MSB step carry_reg is still the carry into the MSB,
            // so the overflow XOR can be formed without a separate latch.
            result_reg         <= sr_next;
            flags_reg.cout     <= fa_cout;
            flags_reg.overflow <= carry_reg ^ fa_cout;
            flags_reg.zero     <= (sr_next == '0);
            state_reg          <= S_DONE;
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign ready    = (state_reg == S_IDLE);
  assign busy     = (state_reg == S_RUN);
  assign done     = (state_reg == S_DONE);
  assign result   = result_reg;
  assign cout     = flags_reg.cout;
  assign overflow = flags_reg.overflow;
  assign zero     = flags_reg.zero;

endmodule
